exu_wb_arb: RTL
===============

# exu_wb_arb

Parametrised writeback arbiter for the execution unit. Sits between the NUM_CH functional units (ALU, MUL, DIV, LSU, future units) and the IDU1 register-file write port. Each unit pushes results into its own small queue, and a round-robin arbiter drains one result per cycle to a single registered writeback port. Simultaneous completions are serialised without loss, and per-channel backpressure is returned to the units.

## Interface
Parameters:
- NUM_CH, 4, number of producer channels (2..8).
- XLEN, 32, data width.
- DEPTH, 2, entries per channel queue (power of 2, 1..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all queued results.
- ch_valid  in  NUM_CH  per-channel result valid.
- ch_ready  out  NUM_CH  per-channel queue not full.
- ch_data  in  NUM_CH*XLEN  result data; channel i occupies [i*XLEN +: XLEN].
- ch_rd_addr  in  NUM_CH*5  destination register; channel i occupies [i*5 +: 5].
- ch_tag  in  NUM_CH*XLEN  debug instruction tag; exists only when the macro below is enabled.
- wb_data  out  XLEN  writeback data.
- wb_rd_addr  out  5  writeback register address.
- wb_rd_wr_en  out  1  one-cycle writeback strobe.
- wb_ch  out  $clog2(NUM_CH)  index of the winning channel.
- wb_tag  out  XLEN  debug tag of the winning entry; exists only when the macro below is enabled.
- busy  out  1  high while any queue is non-empty or wb_rd_wr_en is high.

## Operation
- Per-channel FIFO:
  - DEPTH entries, each holding {data, rd_addr[, tag]}.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Each FIFO has a count of $clog2(DEPTH)+1 bits.
- ch_ready[i] = (count_i != DEPTH). It depends on count only, so there is no pop-through when full.
- Push: ch_valid[i] && ch_ready[i] && !flush.
  - If rd_addr == 0, the push is accepted (handshake completes) but nothing is enqueued.
- Arbitration (combinational, every cycle):
  - Request vector = the non-empty queues.
  - The winner is the first requester at or after rr_ptr, scanning upward modulo NUM_CH.
  - The winner's head entry is popped and loaded into the output register.
  - rr_ptr is updated to (winner+1) mod NUM_CH.
  - If there are no requests, rr_ptr holds.
- Output register: wb_data, wb_rd_addr, wb_ch and wb_tag load on a grant. wb_rd_wr_en = 1 for exactly the cycle following the grant edge.
- With no grant: wb_rd_wr_en = 0, and the data, address, channel and tag outputs hold their last values.
- A push and a pop on the same channel in the same cycle are legal (count unchanged), provided the queue was not full before the push.
- Flush:
  - At the edge: all counts and pointers are zeroed, rr_ptr is set to 0, and wb_rd_wr_en is 0 in the next cycle.
  - Pushes and grants in the flush cycle are discarded.
  - ch_ready is still driven from the pre-flush count.
- Reset (asynchronous, also mid-operation):
  - Counts, pointers, rr_ptr, wb_rd_wr_en, wb_data, wb_rd_addr, wb_ch and wb_tag all go to 0 immediately.
  - Consequently ch_ready goes to all-ones and busy to 0.
  - Queue storage is not cleared.

## Timing
- Minimum latency: a result pushed at edge k is granted at edge k+1 and appears on wb_* with wb_rd_wr_en = 1 during cycle k+1..k+2.
- Throughput: one writeback per cycle aggregate.
- Worst-case wait for a non-empty channel: NUM_CH-1 grants.
- All four channels completing at edge k write back in cycles k+1, k+2, k+3, k+4, in round-robin order starting from rr_ptr.
- Producers must hold ch_valid and the payload until they see ch_ready high at an edge.

## Configuration
- EXU_WB_ARB_TAG_EN:
  - Defined: ch_tag and wb_tag ports exist, and the tag is stored per entry and forwarded with its data.
  - Undefined: the ports, the tag storage and the tag muxing are absent, and all other behaviour is identical. Use this for synthesis builds.

## Test plan
- Single result: channel 2 pushes data 0xDEADBEEF to rd 7 at edge 1 -> one cycle later wb_rd_wr_en = 1, wb_data = 0xDEADBEEF, wb_rd_addr = 7, wb_ch = 2; the strobe is low the cycle after.
- Simultaneous completion: all 4 channels push at the same edge with rr_ptr = 0 -> four consecutive strobes with wb_ch = 0, 1, 2, 3; no loss; busy drops after the last.
- Fairness: channels 0 and 3 push back-to-back continuously -> grants alternate 0, 3, 0, 3…; neither starves.
- Backpressure (DEPTH = 2): channel 1 pushes 3 consecutive results while channel 0 wins arbitration -> ch_ready[1] = 0 after 2 entries, the third is held by the producer and accepted later, and results appear in push order.
- rd 0 and flush: a push with rd_addr = 0 -> handshake completes with no strobe. Flush asserted while 3 entries are queued -> no strobes afterwards, counts 0, rr_ptr 0.
- Reset mid-operation: assert rst while queues are non-empty and wb_rd_wr_en = 1 -> outputs go to 0 asynchronously, ch_ready goes all-ones, and no stale strobe appears after rst deasserts.

Source files
------------

// File: rtl/exu_wb_arb.sv
// exu_wb_arb: per-channel result queues drained round-robin into one registered writeback port.
// Latency: a result pushed at edge k is granted at edge k+1; wb_rd_wr_en is high during cycle k+1..k+2.
// Backpressure: ch_ready[i] is low while queue i is full (count only, no pop-through). Debug tag macro: EXU_WB_ARB_TAG_EN.

// exu_wb_fifo: small circular queue with synchronous flush; entry storage is never cleared.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: none internal; the owner never pushes when full nor pops when empty.
module exu_wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_wdat,
    output logic [W-1:0]  o_rdat,
    output logic [CW-1:0] o_count
);
    // DEPTH of 1 still needs a one-bit pointer; the wrap below keeps it at zero.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Entry storage: written on push only, left untouched by reset and flush.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_wdat;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_push) r_wptr <= f_inc(r_wptr);
            if (i_pop)  r_rptr <= f_inc(r_rptr);
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    assign o_rdat  = r_mem[r_rptr];
    assign o_count = r_cnt;
endmodule

module exu_wb_arb #(
    parameter int NUM_CH = 4,
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH*XLEN-1:0]    ch_data,
    input  logic [NUM_CH*5-1:0]       ch_rd_addr,
`ifdef EXU_WB_ARB_TAG_EN
    input  logic [NUM_CH*XLEN-1:0]    ch_tag,
    output logic [XLEN-1:0]           wb_tag,
`endif
    output logic [XLEN-1:0]           wb_data,
    output logic [4:0]                wb_rd_addr,
    output logic                      wb_rd_wr_en,
    output logic [$clog2(NUM_CH)-1:0] wb_ch,
    output logic                      busy
);
    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef EXU_WB_ARB_TAG_EN
    localparam int EW = 2 * XLEN + 5;
`else
    localparam int EW = XLEN + 5;
`endif

    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_req;
    logic [CW-1:0]     w_cnt  [NUM_CH];
    logic [EW-1:0]     w_head [NUM_CH];
    logic [EW-1:0]     w_sel;
    logic              w_gnt_vld;
    logic [IW-1:0]     w_gnt_idx;
    logic [IW-1:0]     w_rr_nxt;
    logic [IW-1:0]     r_rr_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [EW-1:0] w_wdat;
`ifdef EXU_WB_ARB_TAG_EN
            assign w_wdat = {ch_tag[gi*XLEN +: XLEN], ch_rd_addr[gi*5 +: 5], ch_data[gi*XLEN +: XLEN]};
`else
            assign w_wdat = {ch_rd_addr[gi*5 +: 5], ch_data[gi*XLEN +: XLEN]};
`endif
            assign ch_ready[gi] = (w_cnt[gi] != CW'(DEPTH));
            assign w_req[gi]    = (w_cnt[gi] != '0);
            // Writes to x0 complete the handshake but are dropped here.
            assign w_push[gi]   = ch_valid[gi] & ch_ready[gi] & ~flush & (ch_rd_addr[gi*5 +: 5] != 5'd0);
            assign w_pop[gi]    = w_gnt_vld & (w_gnt_idx == IW'(gi)) & ~flush;

            exu_wb_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .i_flush (flush),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_wdat  (w_wdat),
                .o_rdat  (w_head[gi]),
                .o_count (w_cnt[gi])
            );
        end
    endgenerate

    // Round-robin pick: scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        int j;
        j         = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_rr_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            j = (int'(r_rr_ptr) + k) % NUM_CH;
            if (w_req[j]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = IW'(j);
            end
        end
        w_rr_nxt = (int'(w_gnt_idx) == NUM_CH - 1) ? '0 : w_gnt_idx + IW'(1);
    end

    assign w_sel = w_head[w_gnt_idx];

    // Writeback register: loads the winner on a grant, holds payload otherwise; flush kills the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            wb_rd_wr_en <= 1'b0;
            wb_data     <= '0;
            wb_rd_addr  <= '0;
            wb_ch       <= '0;
`ifdef EXU_WB_ARB_TAG_EN
            wb_tag      <= '0;
`endif
        end else if (flush) begin
            r_rr_ptr    <= '0;
            wb_rd_wr_en <= 1'b0;
        end else begin
            wb_rd_wr_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rr_ptr   <= w_rr_nxt;
                wb_data    <= w_sel[XLEN-1:0];
                wb_rd_addr <= w_sel[XLEN +: 5];
                wb_ch      <= w_gnt_idx;
`ifdef EXU_WB_ARB_TAG_EN
                wb_tag     <= w_sel[XLEN+5 +: XLEN];
`endif
            end
        end
    end

    assign busy = (|w_req) | wb_rd_wr_en;
endmodule
